// File: rtl/fp16_pkg.sv
// Shared FP16 types, constants and the accumulator FSM state encoding.
package fp16_pkg;

    typedef logic [15:0] fp16_t;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } status_t;

    typedef enum logic [2:0] {
        RNE = 3'd0,
        RTZ = 3'd1,
        RDN = 3'd2,
        RUP = 3'd3,
        RMM = 3'd4
    } roundmode_e;

    localparam fp16_t FP16_POS_ZERO = 16'h0000;
    localparam fp16_t FP16_POS_INF  = 16'h7C00;
    localparam fp16_t FP16_QNAN     = 16'h7E00;

    typedef enum logic [1:0] {
        StIdle,
        StAcc,
        StDone
    } accum_state_e;

endpackage

// File: rtl/fp16_add.sv
// Combinational FP16 adder: exact fixed-point sum of both operands, then a single rounding step.
module fp16_add
    import fp16_pkg::*;
(
    input  logic [31:0] operands_i,
    input  logic [2:0]  is_boxed_i,
    input  roundmode_e  rnd_mode_i,
    output fp16_t       result_o,
    output status_t     status_o
);

    // Every finite FP16 value is an integer multiple of 2^-24 below 2^40.
    function automatic logic [40:0] fix_mag(input fp16_t x);
        if (x[14:10] == 5'd0) return {31'd0, x[9:0]};
        return {30'd0, 1'b1, x[9:0]} << (x[14:10] - 5'd1);
    endfunction

    fp16_t              a, b;
    logic               a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;
    logic signed [41:0] a_s, b_s, sum;
    logic [40:0]        s_mag;
    logic               s_neg, guard, sticky, up, to_zero, ovf;
    logic [5:0]         p, shift, sh_m1, exp_f;
    logic [10:0]        keep;
    logic [11:0]        mant12;
    logic               unused_boxed;

    assign a = is_boxed_i[1] ? operands_i[31:16] : FP16_QNAN;
    assign b = is_boxed_i[0] ? operands_i[15:0] : FP16_QNAN;
    assign unused_boxed = is_boxed_i[2];

    always_comb begin
        a_inf  = (a[14:0] == FP16_POS_INF[14:0]);
        b_inf  = (b[14:0] == FP16_POS_INF[14:0]);
        a_nan  = (a[14:10] == 5'h1F) && (a[9:0] != 10'd0);
        b_nan  = (b[14:10] == 5'h1F) && (b[9:0] != 10'd0);
        a_snan = a_nan && !a[9];
        b_snan = b_nan && !b[9];
        a_zero = (a[14:0] == 15'd0);
        b_zero = (b[14:0] == 15'd0);

        a_s   = a[15] ? -$signed({1'b0, fix_mag(a)}) : $signed({1'b0, fix_mag(a)});
        b_s   = b[15] ? -$signed({1'b0, fix_mag(b)}) : $signed({1'b0, fix_mag(b)});
        sum   = a_s + b_s;
        s_neg = sum[41];
        s_mag = s_neg ? 41'(-sum) : 41'(sum);

        p = 6'd0;
        for (int i = 0; i < 41; i++) begin
            if (s_mag[i]) p = 6'(i);
        end
        shift  = (p > 6'd10) ? p - 6'd10 : 6'd0;
        sh_m1  = shift - 6'd1;
        keep   = 11'(s_mag >> shift);
        guard  = (shift != 6'd0) && |(s_mag & (41'd1 << sh_m1));
        sticky = (shift != 6'd0) && |(s_mag & ((41'd1 << sh_m1) - 41'd1));

        case (rnd_mode_i)
            RTZ:     up = 1'b0;
            RDN:     up = s_neg & (guard | sticky);
            RUP:     up = ~s_neg & (guard | sticky);
            RMM:     up = guard;
            default: up = guard & (sticky | keep[0]);
        endcase
        to_zero = (rnd_mode_i == RTZ) || (rnd_mode_i == RDN && !s_neg) ||
                  (rnd_mode_i == RUP && s_neg);

        mant12 = {1'b0, keep} + 12'(up);
        exp_f  = p - 6'd9 + 6'(mant12[11]);
        ovf    = (exp_f >= 6'd31);

        result_o = FP16_POS_ZERO;
        status_o = '0;
        if (a_nan || b_nan) begin
            result_o    = FP16_QNAN;
            status_o.nv = a_snan | b_snan;
        end else if (a_inf && b_inf && (a[15] != b[15])) begin
            result_o    = FP16_QNAN;
            status_o.nv = 1'b1;
        end else if (a_inf) begin
            result_o = a;
        end else if (b_inf) begin
            result_o = b;
        end else if (s_mag == 41'd0) begin
            // Exact zero: keep a shared sign, otherwise +0 except when rounding down.
            result_o[15] = (a_zero && b_zero && (a[15] == b[15])) ? a[15] : (rnd_mode_i == RDN);
        end else if (p <= 6'd10) begin
            result_o = {s_neg, s_mag[14:0]};
        end else if (ovf) begin
            result_o    = to_zero ? {s_neg, 15'h7BFF} : {s_neg, FP16_POS_INF[14:0]};
            status_o.of = 1'b1;
            status_o.nx = 1'b1;
        end else begin
            result_o    = {s_neg, exp_f[4:0], mant12[9:0]};
            status_o.nx = guard | sticky;
        end
    end

endmodule

// File: rtl/fp16_accum.sv
// Streaming FP16 sum reduction around one fp16_add; sticky flags built only with
// FP16_ACCUM_STATUS_EN defined, otherwise status_o is tied to zero.
module fp16_accum
    import fp16_pkg::*;
#(
    parameter int unsigned MAX_LEN = 256,
    localparam int unsigned LW = $clog2(MAX_LEN + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          start_i,
    input  logic [LW-1:0] len_i,
    input  logic [2:0]    rnd_mode_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [15:0]   in_data_i,
    output logic          sum_valid_o,
    input  logic          sum_ready_i,
    output logic [15:0]   sum_o,
    output logic [4:0]    status_o,
    output logic          busy_o
);

    accum_state_e  state_q, state_d;
    logic [LW-1:0] len_q, len_d, cnt_q, cnt_d, len_clamped;
    fp16_t         acc_q, acc_d, add_result;
    roundmode_e    rnd_q, rnd_d;
    status_t       add_status;

    fp16_add u_add (
        .operands_i ({acc_q, in_data_i}),
        .is_boxed_i (3'b111),
        .rnd_mode_i (rnd_q),
        .result_o   (add_result),
        .status_o   (add_status)
    );

    assign len_clamped = (len_i > LW'(MAX_LEN)) ? LW'(MAX_LEN) : len_i;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        rnd_d       = rnd_q;
        in_ready_o  = 1'b0;
        sum_valid_o = 1'b0;
        busy_o      = 1'b0;
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    len_d   = len_clamped;
                    rnd_d   = roundmode_e'(rnd_mode_i);
                    acc_d   = FP16_POS_ZERO;
                    cnt_d   = '0;
                    state_d = (len_clamped == '0) ? StDone : StAcc;
                end
            end
            StAcc: begin
                busy_o     = 1'b1;
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    acc_d = add_result;
                    cnt_d = cnt_q + LW'(1);
                    if (cnt_q + LW'(1) == len_q) state_d = StDone;
                end
            end
            StDone: begin
                busy_o      = 1'b1;
                sum_valid_o = 1'b1;
                if (sum_ready_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            len_q   <= '0;
            cnt_q   <= '0;
            acc_q   <= FP16_POS_ZERO;
            rnd_q   <= RNE;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            rnd_q   <= rnd_d;
        end
    end

    assign sum_o = acc_q;

`ifdef FP16_ACCUM_STATUS_EN
    status_t status_q, status_d;

    always_comb begin
        status_d = status_q;
        if (state_q == StIdle && start_i) begin
            status_d = '0;
        end else if (state_q == StAcc && in_valid_i) begin
            status_d = status_q | add_status;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) status_q <= '0;
        else         status_q <= status_d;
    end

    assign status_o = status_q;
`else
    logic unused_add_status;
    assign unused_add_status = ^add_status;
    assign status_o = 5'b00000;
`endif

endmodule

// File: tb/tb_fp16_accum.sv
// Directed and randomized runs of fp16_accum checked against a real-arithmetic FP16 model.
module tb_fp16_accum;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [8:0]  len = '0;
    logic [2:0]  rnd = '0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        sum_ready = 1'b0;
    logic        in_ready, sum_valid, busy;
    logic [15:0] sum;
    logic [4:0]  status;
    int          n_checks = 0;
    int          n_pass = 0;
    int          hs_cnt = 0;

    fp16_accum dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start),
        .len_i       (len),
        .rnd_mode_i  (rnd),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .sum_valid_o (sum_valid),
        .sum_ready_i (sum_ready),
        .sum_o       (sum),
        .status_o    (status),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (in_valid && in_ready) hs_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic real pow2(input int k);
        real r = 1.0;
        if (k >= 0) for (int i = 0; i < k; i++) r = r * 2.0;
        else for (int i = 0; i < -k; i++) r = r / 2.0;
        return r;
    endfunction

    function automatic real to_real(input logic [15:0] h);
        real v;
        int  e = int'(h[14:10]);
        int  m = int'(h[9:0]);
        v = (e == 0) ? m * pow2(-24) : (1024 + m) * pow2(e - 25);
        return h[15] ? -v : v;
    endfunction

    // IEEE-754 binary16 addition: exact real sum, then round to the target format.
    function automatic void ref_add(input logic [15:0] a, input logic [15:0] b,
                                    input logic [2:0] rm, output logic [15:0] r,
                                    output logic [4:0] f);
        logic an, bn, ai, bi, neg, inexact;
        real  x, m, q, n, frac, v;
        int   e, fl, up;
        an = (a[14:10] == 5'h1F) && (a[9:0] != 0);
        bn = (b[14:10] == 5'h1F) && (b[9:0] != 0);
        ai = (a[14:0] == 15'h7C00);
        bi = (b[14:0] == 15'h7C00);
        f  = '0;
        r  = '0;
        if (an || bn) begin
            r = 16'h7E00;
            if ((an && !a[9]) || (bn && !b[9])) f = 5'b10000;
            return;
        end
        if (ai && bi && (a[15] != b[15])) begin
            r = 16'h7E00;
            f = 5'b10000;
            return;
        end
        if (ai) begin r = a; return; end
        if (bi) begin r = b; return; end
        x = to_real(a) + to_real(b);
        if (x == 0.0) begin
            if (a[14:0] == 0 && b[14:0] == 0 && a[15] == b[15]) r = {a[15], 15'd0};
            else r = (rm == 3'd2) ? 16'h8000 : 16'h0000;
            return;
        end
        neg = (x < 0.0);
        m   = neg ? -x : x;
        e   = -24;
        while (pow2(e + 1) <= m) e++;
        if (e < -14) e = -14;
        q       = pow2(e - 10);
        n       = m / q;
        fl      = $rtoi(n);
        frac    = n - fl;
        inexact = (frac != 0.0);
        case (rm)
            3'd1:    up = 0;
            3'd2:    up = (neg && inexact) ? 1 : 0;
            3'd3:    up = (!neg && inexact) ? 1 : 0;
            3'd4:    up = (frac >= 0.5) ? 1 : 0;
            default: up = (frac > 0.5 || (frac == 0.5 && (fl % 2) == 1)) ? 1 : 0;
        endcase
        v = (fl + up) * q;
        if (v >= 65536.0) begin
            f = 5'b00101;
            if (rm == 3'd1 || (rm == 3'd2 && !neg) || (rm == 3'd3 && neg)) r = {neg, 15'h7BFF};
            else r = {neg, 15'h7C00};
            return;
        end
        if (inexact) f = 5'b00001;
        if (v < pow2(-14)) begin
            r = {neg, 5'd0, 10'($rtoi(v / pow2(-24)))};
        end else begin
            e = -14;
            while (pow2(e + 1) <= v) e++;
            fl = $rtoi(v / pow2(e - 10)) - 1024;
            r  = {neg, 5'(e + 15), 10'(fl)};
        end
    endfunction

    function automatic void ref_run(input logic [15:0] d[$], input logic [2:0] rm,
                                    output logic [15:0] s, output logic [4:0] st);
        logic [15:0] r;
        logic [4:0]  f;
        s  = 16'h0000;
        st = '0;
        foreach (d[i]) begin
            ref_add(s, d[i], rm, r, f);
            s  = r;
            st = st | f;
        end
    endfunction

    function automatic logic [15:0] rand_fp16();
        logic [15:0] v = 16'($urandom);
        case ($urandom_range(0, 9))
            0:       v[14:10] = 5'h1F;
            1:       v[14:10] = 5'h00;
            2:       v[14:0] = '0;
            3:       v[14:10] = 5'h1E;
            default: v[14:10] = 5'($urandom_range(10, 20));
        endcase
        return v;
    endfunction

    // One complete run; expected values from the model unless use_exp supplies constants.
    task automatic run(input string tag, input logic [8:0] len_in, input logic [2:0] rm,
                       input logic [15:0] d[$], input int gap, input bit use_exp,
                       input logic [15:0] x_sum, input logic [4:0] x_st);
        logic [15:0] es;
        logic [4:0]  est;
        int          base;
        ref_run(d, rm, es, est);
        if (use_exp) begin
            es  = x_sum;
            est = x_st;
        end
`ifndef FP16_ACCUM_STATUS_EN
        est = '0;
`endif
        @(negedge clk);
        start = 1'b1;
        len   = len_in;
        rnd   = rm;
        @(negedge clk);
        start = 1'b0;
        len   = 9'($urandom);
        rnd   = 3'($urandom);
        base  = hs_cnt;
        foreach (d[i]) begin
            repeat (gap) begin
                in_valid = 1'b0;
                start    = 1'b1;
                in_data  = 16'($urandom);
                @(negedge clk);
            end
            start    = 1'b0;
            in_valid = 1'b1;
            in_data  = d[i];
            if (i == d.size() - 1) check({tag, " valid_before_last"}, 32'(sum_valid), 32'd0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check({tag, " sum_valid"}, 32'(sum_valid), 32'd1);
        check({tag, " sum"}, 32'(sum), 32'(es));
        check({tag, " status"}, 32'(status), 32'(est));
        check({tag, " handshakes"}, 32'(hs_cnt - base), 32'(d.size()));
        sum_ready = 1'b1;
        @(negedge clk);
        sum_ready = 1'b0;
        check({tag, " idle_valid"}, 32'(sum_valid), 32'd0);
        check({tag, " idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [15:0] dq[$];
        logic [4:0]  st_ovf, st_nv;
        int          n;

        st_ovf = 5'b00101;
        st_nv  = 5'b10000;
        #12;
        check("rst in_ready", 32'(in_ready), 32'd0);
        check("rst sum_valid", 32'(sum_valid), 32'd0);
        check("rst sum", 32'(sum), 32'd0);
        check("rst status", 32'(status), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        dq = {16'h3E00, 16'h3E00};
        run("two_halves", 9'd2, 3'd0, dq, 0, 1'b1, 16'h4200, 5'b00000);
        dq = {16'h3E00, 16'h3E00, 16'h3E00};
        run("gapped", 9'd3, 3'd0, dq, 2, 1'b1, 16'h4480, 5'b00000);
        dq = {16'h7BFF, 16'h7BFF};
        run("overflow", 9'd2, 3'd0, dq, 0, 1'b1, 16'h7C00, st_ovf);
        dq = {16'h7C00, 16'hFC00, 16'h3C00};
        run("inf_minus_inf", 9'd3, 3'd0, dq, 1, 1'b1, 16'h7E00, st_nv);

        dq = {};
        for (int i = 0; i < 256; i++) dq.push_back(16'h3C00);
        run("clamp", 9'd300, 3'd0, dq, 0, 1'b1, 16'h5C00, 5'b00000);

        // Zero-length run followed by result backpressure.
        @(negedge clk);
        start = 1'b1;
        len   = 9'd0;
        @(negedge clk);
        start = 1'b0;
        check("len0 sum_valid", 32'(sum_valid), 32'd1);
        check("len0 sum", 32'(sum), 32'd0);
        check("len0 busy", 32'(busy), 32'd1);
        for (int i = 0; i < 5; i++) begin
            start    = 1'b1;
            len      = 9'd3;
            in_valid = 1'b1;
            in_data  = 16'h3C00;
            @(negedge clk);
            check("hold sum_valid", 32'(sum_valid), 32'd1);
            check("hold sum", 32'(sum), 32'd0);
            check("hold status", 32'(status), 32'd0);
            check("hold busy", 32'(busy), 32'd1);
            check("hold in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        sum_ready = 1'b1;
        start     = 1'b1;
        len       = 9'd2;
        @(negedge clk);
        sum_ready = 1'b0;
        start     = 1'b0;
        check("done_start busy", 32'(busy), 32'd0);
        check("done_start in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("done_start idle", 32'(busy), 32'd0);

        // Asynchronous reset after the first of four elements.
        @(negedge clk);
        start = 1'b1;
        len   = 9'd4;
        rnd   = 3'd0;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 16'h3C00;
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("midrst in_ready", 32'(in_ready), 32'd0);
        check("midrst sum_valid", 32'(sum_valid), 32'd0);
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst sum", 32'(sum), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dq = {16'h3C00, 16'h4000, 16'h3800, 16'h3400};
        run("post_reset", 9'd4, 3'd0, dq, 0, 1'b0, '0, '0);

        for (int r = 0; r < 25; r++) begin
            dq = {};
            n  = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) dq.push_back(rand_fp16());
            run($sformatf("rand%0d", r), 9'(n), 3'($urandom_range(0, 4)), dq,
                $urandom_range(0, 1), 1'b0, '0, '0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
